// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests one instruction at a time, holds it for the
// control unit while the branch resolves, then picks the next PC.
module fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR      = 32'h0000_0013,
  parameter int unsigned RESOLVE_CYCLES = 2,
  parameter int unsigned TIMEOUT        = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  input  logic        pc_sel,
  input  logic [31:0] alu_out,
  input  logic        stall,
  output logic        fetch_err
);

  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_ISSUE, S_HOLD} state_t;

  localparam logic [2:0] RESOLVE_LAST = 3'(RESOLVE_CYCLES - 1);
  localparam logic [7:0] WAIT_LAST    = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [7:0]  wait_q, wait_d;
  logic [2:0]  resolve_q, resolve_d;

  logic        decideNow;
  logic [31:0] nextPc;
  logic        alu_unused;

  assign alu_unused = ^alu_out[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_BOOT;
      pc_q      <= RESET_PC;
      instr_q   <= NOP_INSTR;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      wait_q    <= '0;
      resolve_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      wait_q    <= wait_d;
      resolve_q <= resolve_d;
    end
  end

  // The branch decision is taken either in the last resolve cycle or on the
  // first unstalled cycle of a hold; pc_sel/alu_out matter only then.
  always_comb begin
    decideNow = !stall &&
                (((state_q == S_ISSUE) && (resolve_q == RESOLVE_LAST)) ||
                 (state_q == S_HOLD));
    nextPc    = pc_sel ? {alu_out[31:2], 2'b00} : pc_q + 32'd4;
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    valid_d   = valid_q;
    err_d     = err_q;
    wait_d    = wait_q;
    resolve_d = resolve_q;

    case (state_q)
      S_BOOT: begin
        state_d = S_FETCH;
        wait_d  = '0;
      end
      S_FETCH: begin
        // Timeout wins over an ack arriving in the same cycle.
        if (wait_q == WAIT_LAST) begin
          err_d     = 1'b1;
          instr_d   = NOP_INSTR;
          valid_d   = 1'b1;
          wait_d    = '0;
          resolve_d = '0;
          state_d   = S_ISSUE;
        end else if (imem_ack) begin
          instr_d   = imem_rdata;
          valid_d   = 1'b1;
          wait_d    = '0;
          resolve_d = '0;
          state_d   = S_ISSUE;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_ISSUE: begin
        if (resolve_q == RESOLVE_LAST) begin
          if (stall) state_d = S_HOLD;
        end else begin
          resolve_d = resolve_q + 3'd1;
        end
      end
      S_HOLD: ;
      default: state_d = S_BOOT;
    endcase

    if (decideNow) begin
      pc_d      = nextPc;
      instr_d   = NOP_INSTR;
      valid_d   = 1'b0;
      wait_d    = '0;
      resolve_d = '0;
      state_d   = S_FETCH;
    end
  end

  assign imem_req    = (state_q == S_FETCH);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign fetch_err   = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit: a transaction-level reference model predicts
// every output each cycle; a second instance exercises PC wrap and async reset.
module tb_fetch_unit;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam int          RCYC     = 2;
  localparam int          TMO      = 15;
  localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFFC;

  logic        clk;
  logic        rst_n;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemRdata;
  logic [31:0] instrOut;
  logic        instrValid;
  logic [31:0] pcOut;
  logic        pcSel;
  logic [31:0] aluOut;
  logic        stallIn;
  logic        fetchErr;

  logic        rst2N;
  logic        imemReq2;
  logic [31:0] imemAddr2;
  logic        imemAck2;
  logic [31:0] imemRdata2;
  logic [31:0] instrOut2;
  logic        instrValid2;
  logic [31:0] pcOut2;
  logic        pcSel2;
  logic [31:0] aluOut2;
  logic        stallIn2;
  logic        fetchErr2;

  int compareCount;
  int mismatchCount;

  // Reference model: "fetching" vs "issued", counting cycles waited and the
  // age of the issued instruction; a hold is simply an old, stalled issue.
  logic        mBoot;
  logic        mFetching;
  int          mWait;
  int          mAge;
  logic [31:0] mPc;
  logic [31:0] mInstr;
  logic        mValid;
  logic        mErr;

  fetch_unit #(
    .RESET_PC(32'h0000_0000), .NOP_INSTR(NOP),
    .RESOLVE_CYCLES(RCYC), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imemReq), .imem_addr(imemAddr),
    .imem_ack(imemAck), .imem_rdata(imemRdata),
    .instr(instrOut), .instr_valid(instrValid), .pc(pcOut),
    .pc_sel(pcSel), .alu_out(aluOut), .stall(stallIn),
    .fetch_err(fetchErr)
  );

  fetch_unit #(
    .RESET_PC(WRAP_PC), .NOP_INSTR(NOP),
    .RESOLVE_CYCLES(RCYC), .TIMEOUT(TMO)
  ) dutWrap (
    .clk(clk), .rst_n(rst2N),
    .imem_req(imemReq2), .imem_addr(imemAddr2),
    .imem_ack(imemAck2), .imem_rdata(imemRdata2),
    .instr(instrOut2), .instr_valid(instrValid2), .pc(pcOut2),
    .pc_sel(pcSel2), .alu_out(aluOut2), .stall(stallIn2),
    .fetch_err(fetchErr2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mBoot     = 1'b1;
    mFetching = 1'b0;
    mWait     = 0;
    mAge      = 0;
    mPc       = 32'h0000_0000;
    mInstr    = NOP;
    mValid    = 1'b0;
    mErr      = 1'b0;
  endtask

  task automatic modelStep(input logic ack, input logic [31:0] rdata,
                           input logic st, input logic sel,
                           input logic [31:0] alu);
    if (mBoot) begin
      mBoot     = 1'b0;
      mFetching = 1'b1;
      mWait     = 0;
    end else if (mFetching) begin
      mWait = mWait + 1;
      if (mWait == TMO) begin
        mErr      = 1'b1;
        mInstr    = NOP;
        mValid    = 1'b1;
        mFetching = 1'b0;
        mAge      = 0;
      end else if (ack) begin
        mInstr    = rdata;
        mValid    = 1'b1;
        mFetching = 1'b0;
        mAge      = 0;
      end
    end else begin
      if (mAge >= RCYC - 1 && !st) begin
        mPc       = sel ? (alu & ~32'd3) : mPc + 32'd4;
        mInstr    = NOP;
        mValid    = 1'b0;
        mFetching = 1'b1;
        mWait     = 0;
      end else begin
        mAge = mAge + 1;
      end
    end
  endtask

  // Called at a falling edge: check outputs, drive inputs, advance the model,
  // then return at the next falling edge.
  task automatic applyStimulus(input logic ack, input logic [31:0] rdata,
                               input logic st, input logic sel,
                               input logic [31:0] alu);
    checkOutput("req",   {31'd0, imemReq},    {31'd0, (mFetching && !mBoot)});
    checkOutput("addr",  imemAddr,            mPc);
    checkOutput("instr", instrOut,            mInstr);
    checkOutput("valid", {31'd0, instrValid}, {31'd0, mValid});
    checkOutput("pc",    pcOut,               mPc);
    checkOutput("err",   {31'd0, fetchErr},   {31'd0, mErr});
    imemAck   = ack;
    imemRdata = rdata;
    stallIn   = st;
    pcSel     = sel;
    aluOut    = alu;
    modelStep(ack, rdata, st, sel, alu);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    rst_n = 1'b0; imemAck = 1'b0; imemRdata = '0;
    pcSel = 1'b0; aluOut = '0; stallIn = 1'b0;
    rst2N = 1'b0; imemAck2 = 1'b0; imemRdata2 = '0;
    pcSel2 = 1'b0; aluOut2 = '0; stallIn2 = 1'b0;
    modelReset();

    repeat (2) @(negedge clk);
    checkOutput("rstReq",   {31'd0, imemReq},    32'd0);
    checkOutput("rstInstr", instrOut,            NOP);
    checkOutput("rstValid", {31'd0, instrValid}, 32'd0);
    checkOutput("rstPc",    pcOut,               32'd0);
    checkOutput("rstErr",   {31'd0, fetchErr},   32'd0);
    rst_n = 1'b1;

    // Boot, one idle fetch cycle, then the ack.
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("firstAddr", imemAddr, 32'h0);
    applyStimulus(1'b1, 32'h0020_8033, 1'b0, 1'b0, 32'h0);
    checkOutput("firstInstrA", instrOut, 32'h0020_8033);
    checkOutput("firstValidA", {31'd0, instrValid}, 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0800);
    checkOutput("firstInstrB", instrOut, 32'h0020_8033);
    checkOutput("firstValidB", {31'd0, instrValid}, 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("secondAddr", imemAddr, 32'h4);
    checkOutput("secondReq", {31'd0, imemReq}, 32'd1);

    // Reach pc=8, then branch to 0x103 (aligned to 0x100).
    applyStimulus(1'b1, $urandom, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("addr8", imemAddr, 32'h8);
    applyStimulus(1'b1, $urandom, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0103);
    checkOutput("branchAddr", imemAddr, 32'h0000_0100);

    // Stall across the decision for 5 cycles, then fall through.
    applyStimulus(1'b1, 32'hCAFE_0001, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_5000);
    for (int i = 0; i < 4; i++) begin
      checkOutput("holdReq", {31'd0, imemReq}, 32'd0);
      checkOutput("holdInstr", instrOut, 32'hCAFE_0001);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_5000);
    end
    checkOutput("holdPc", pcOut, 32'h0000_0100);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("resumeAddr", imemAddr, 32'h0000_0104);

    // Timeout: the ack in the 15th cycle must be ignored.
    for (int i = 1; i <= TMO; i++)
      applyStimulus(i == TMO, 32'h1111_2222, 1'b0, 1'b0, 32'h0);
    checkOutput("tmoErr", {31'd0, fetchErr}, 32'd1);
    checkOutput("tmoInstr", instrOut, NOP);
    checkOutput("tmoValid", {31'd0, instrValid}, 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("tmoNextAddr", imemAddr, 32'h0000_0108);

    // Random traffic with occasional asynchronous reset pulses.
    for (int i = 0; i < 1500; i++) begin
      int ackPct;
      ackPct = (i < 1000) ? 50 : 4;
      if ($urandom_range(0, 99) == 0) begin
        #1 rst_n = 1'b0;
        #1;
        checkOutput("asyncReq", {31'd0, imemReq}, 32'd0);
        checkOutput("asyncPc", pcOut, 32'd0);
        checkOutput("asyncErr", {31'd0, fetchErr}, 32'd0);
        #1 rst_n = 1'b1;
        modelReset();
      end
      applyStimulus($urandom_range(0, 99) < ackPct, $urandom,
                    $urandom_range(0, 3) == 0, 1'($urandom), $urandom);
    end

    // Wrap-around instance: fetch at 0xFFFFFFFC, then sequential PC wraps to 0.
    rst2N = 1'b0;
    @(negedge clk);
    checkOutput("wrapRstAddr", imemAddr2, WRAP_PC);
    checkOutput("wrapRstReq", {31'd0, imemReq2}, 32'd0);
    rst2N = 1'b1;
    @(negedge clk);
    checkOutput("wrapReq1", {31'd0, imemReq2}, 32'd1);
    checkOutput("wrapAddr1", imemAddr2, WRAP_PC);
    imemAck2 = 1'b1; imemRdata2 = 32'h0000_0033;
    @(negedge clk);
    imemAck2 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("wrapReq2", {31'd0, imemReq2}, 32'd1);
    checkOutput("wrapAddr2", imemAddr2, 32'h0);
    checkOutput("wrapErr", {31'd0, fetchErr2}, 32'd0);

    // Reset in the middle of a fetch drops the request without a clock edge.
    #2 rst2N = 1'b0;
    #1;
    checkOutput("midRstReq", {31'd0, imemReq2}, 32'd0);
    checkOutput("midRstAddr", imemAddr2, WRAP_PC);
    #1 rst2N = 1'b1;
    @(negedge clk);
    checkOutput("postRstReq", {31'd0, imemReq2}, 32'd1);
    checkOutput("postRstAddr", imemAddr2, WRAP_PC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compareCount, mismatchCount);
    $finish;
  end

endmodule
